// File: rtl/vram_arbiter.sv
// Two-requester video RAM arbiter: video scan-out has priority, the CPU is protected by a
// starve counter. Every access runs through a fixed two-stage pipeline ending in a registered ack.
module vram_arbiter #(
    parameter int AW           = 12,
    parameter int DW           = 8,
    parameter int STARVE_LIMIT = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Stage 1: RAM addressed this cycle. Stage 2: ram_rdata carries the result this cycle.
    // Owner bit: 1 = CPU, 0 = video.
    logic          s1_v_q, s1_own_q, s1_we_q;
    logic          s2_v_q, s2_own_q, s2_we_q;
    logic          cpu_ack_q, vid_ack_q;
    logic [DW-1:0] rdata_q;
    logic [3:0]    starve_q, starve_d;
    logic          ram_en_q, ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;

    logic cpu_busy, vid_busy, cpu_elig, vid_elig, starved, grant_cpu, grant_vid;

    always_comb begin
        cpu_busy  = (s1_v_q && s1_own_q) || (s2_v_q && s2_own_q);
        vid_busy  = (s1_v_q && !s1_own_q) || (s2_v_q && !s2_own_q);
        cpu_elig  = cpu_req && !cpu_busy;
        vid_elig  = vid_req && !vid_busy;
        starved   = (starve_q == LIMIT);
        grant_cpu = cpu_elig && (!vid_elig || starved);
        grant_vid = vid_elig && !grant_cpu;

        // Counts only cycles where the CPU could have been served but was not; saturates at 15.
        starve_d = starve_q;
        if (!cpu_req || grant_cpu) begin
            starve_d = 4'd0;
        end else if (!cpu_busy && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v_q      <= 1'b0;
            s1_own_q    <= 1'b0;
            s1_we_q     <= 1'b0;
            s2_v_q      <= 1'b0;
            s2_own_q    <= 1'b0;
            s2_we_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            rdata_q     <= '0;
            starve_q    <= 4'd0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            starve_q <= starve_d;

            s1_v_q   <= grant_cpu || grant_vid;
            s1_own_q <= grant_cpu;
            s1_we_q  <= grant_cpu && cpu_we;

            s2_v_q   <= s1_v_q;
            s2_own_q <= s1_own_q;
            s2_we_q  <= s1_we_q;

            cpu_ack_q <= s2_v_q && s2_own_q;
            vid_ack_q <= s2_v_q && !s2_own_q;
            if (s2_v_q && !s2_we_q) begin
                rdata_q <= ram_rdata;
            end

            // Address and data hold their last value while idle.
            ram_en_q <= grant_cpu || grant_vid;
            ram_we_q <= grant_cpu && cpu_we;
            if (grant_cpu) begin
                ram_addr_q  <= cpu_addr;
                ram_wdata_q <= cpu_wdata;
            end else if (grant_vid) begin
                ram_addr_q  <= vid_addr;
            end
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign vid_ack   = vid_ack_q;
    assign cpu_rdata = rdata_q;
    assign vid_rdata = rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: synchronous RAM model, shadow memory, ack-driven scoreboard queues.
module tb_vram_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic [DW-1:0] vid_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] mem    [2**AW];
    logic [DW-1:0] shadow [2**AW];
    logic [DW:0]   cpu_exp_q[$];   // {is_write, expected read data}
    logic [DW-1:0] vid_exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic vid_run = 1'b0;

    vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(7)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Synchronous single-port RAM: read data valid the cycle after ram_en.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard: pop on every ack and compare read data.
    always @(negedge clk) begin
        logic [DW:0] ce;
        if (reset_n) begin
            if (cpu_ack) begin
                if (cpu_exp_q.size() == 0) check("cpu_unexpected_ack", 32'(cpu_ack), 32'd0);
                else begin
                    ce = cpu_exp_q.pop_front();
                    if (!ce[DW]) check("cpu_rdata", 32'(cpu_rdata), 32'(ce[DW-1:0]));
                end
            end
            if (vid_ack) begin
                if (vid_exp_q.size() == 0) check("vid_unexpected_ack", 32'(vid_ack), 32'd0);
                else check("vid_rdata", 32'(vid_rdata), 32'(vid_exp_q.pop_front()));
            end
        end
    end

    // Ideal video model: re-requests in the ack cycle while running, otherwise drops at ack.
    always @(negedge clk) begin
        if (vid_run) begin
            if (!vid_req || vid_ack) begin
                vid_addr = 12'h800 | 12'($urandom_range(0, 2047));
                vid_req  = 1'b1;
                vid_exp_q.push_back(shadow[vid_addr]);
            end
        end else if (vid_req && vid_ack) begin
            vid_req = 1'b0;
        end
    end

    // Driver tasks
    task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              output int gl, output int al);
        cpu_we = we; cpu_addr = addr; cpu_wdata = data; cpu_req = 1'b1;
        if (we) begin
            shadow[addr] = data;
            cpu_exp_q.push_back({1'b1, {DW{1'b0}}});
        end else begin
            cpu_exp_q.push_back({1'b0, shadow[addr]});
        end
        gl = 0; al = 0;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (gl == 0 && ram_en && ram_we == we && ram_addr == addr) gl = t;
            if (cpu_ack) begin al = t; break; end
        end
        cpu_req = 1'b0;
        if (al == 0) check("cpu_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic vid_read(input logic [AW-1:0] addr, output int al);
        vid_addr = addr; vid_req = 1'b1;
        vid_exp_q.push_back(shadow[addr]);
        al = 0;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (vid_ack) begin al = t; break; end
        end
        if (al == 0) check("vid_ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int gl, al, prev;
        for (int i = 0; i < 2**AW; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ram_en",    32'(ram_en),    32'd0);
        check("rst_ram_we",    32'(ram_we),    32'd0);
        check("rst_ram_addr",  32'(ram_addr),  32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_cpu_ack",   32'(cpu_ack),   32'd0);
        check("rst_vid_ack",   32'(vid_ack),   32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // CPU write 0x123 <= 0xA5, cycle by cycle
        cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'hA5; cpu_req = 1'b1;
        shadow[12'h123] = 8'hA5;
        cpu_exp_q.push_back({1'b1, 8'h00});
        @(negedge clk);
        check("wr_ram_en",    32'(ram_en),    32'd1);
        check("wr_ram_we",    32'(ram_we),    32'd1);
        check("wr_ram_addr",  32'(ram_addr),  32'h123);
        check("wr_ram_wdata", 32'(ram_wdata), 32'hA5);
        check("wr_ack_early", 32'(cpu_ack),   32'd0);
        @(negedge clk);
        check("wr_ram_en_one_cycle", 32'(ram_en),  32'd0);
        check("wr_ack_early2",       32'(cpu_ack), 32'd0);
        @(negedge clk);
        check("wr_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        @(negedge clk);
        check("wr_ack_pulse", 32'(cpu_ack), 32'd0);
        check("idle_ram_addr_kept", 32'(ram_addr), 32'h123);
        cpu_access(1'b0, 12'h123, 8'h00, gl, al);
        check("rd_latency", 32'(al), 32'd3);
        repeat (2) @(negedge clk);

        // Mixed uncontended CPU traffic
        for (int k = 0; k < 8; k++) begin
            cpu_access(1'($urandom_range(0, 1)), 12'($urandom_range(0, 2047)),
                       8'($urandom_range(0, 255)), gl, al);
            check("mix_latency", 32'(al), 32'd3);
            if (k % 2 == 1) @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // Simultaneous requests: video first, CPU next, consecutive acks
        vid_addr = 12'h900; vid_req = 1'b1; vid_exp_q.push_back(shadow[12'h900]);
        cpu_we = 1'b0; cpu_addr = 12'h045; cpu_req = 1'b1; cpu_exp_q.push_back({1'b0, shadow[12'h045]});
        @(negedge clk);
        check("both_first_en",   32'(ram_en),   32'd1);
        check("both_first_addr", 32'(ram_addr), 32'h900);
        check("both_first_we",   32'(ram_we),   32'd0);
        @(negedge clk);
        check("both_second_en",   32'(ram_en),   32'd1);
        check("both_second_addr", 32'(ram_addr), 32'h045);
        @(negedge clk);
        check("both_vid_ack", 32'(vid_ack), 32'd1);
        check("both_cpu_ack_not_yet", 32'(cpu_ack), 32'd0);
        @(negedge clk);
        check("both_cpu_ack", 32'(cpu_ack), 32'd1);
        check("both_vid_ack_done", 32'(vid_ack), 32'd0);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);

        // Continuous video traffic: CPU writes must be granted within the starve bound
        vid_run = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            cpu_access(1'b1, 12'($urandom_range(0, 2047)), 8'($urandom_range(0, 255)), gl, al);
            check("starve_grant_seen",  32'(gl != 0), 32'd1);
            check("starve_grant_bound", 32'(gl <= 8), 32'd1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        vid_run = 1'b0;
        for (int t = 0; t < 30 && vid_req; t++) @(negedge clk);
        check("vid_model_drained", 32'(vid_req), 32'd0);
        repeat (3) @(negedge clk);

        // Back-to-back CPU: new request presented in each ack cycle
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 12'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom_range(0, 255));
            cpu_req   = 1'b1;
            if (cpu_we) begin
                shadow[cpu_addr] = cpu_wdata;
                cpu_exp_q.push_back({1'b1, 8'h00});
            end else begin
                cpu_exp_q.push_back({1'b0, shadow[cpu_addr]});
            end
            al = 0;
            for (int t = 1; t <= 30; t++) begin
                @(negedge clk);
                if (cpu_ack) begin al = t; break; end
            end
            if (al == 0) check("b2b_ack_timeout", 32'd0, 32'd1);
            if (k > 0) check("b2b_spacing", 32'(cyc - prev), 32'd3);
            prev = cyc;
        end
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset pulse while a video read sits in stage 1
        vid_addr = 12'hA00; vid_req = 1'b1; vid_exp_q.push_back(shadow[12'hA00]);
        @(negedge clk);
        check("rstmid_stage1_en", 32'(ram_en), 32'd1);
        reset_n = 1'b0; vid_req = 1'b0;
        vid_exp_q.delete();
        #1;
        check("rstmid_ram_en",   32'(ram_en),   32'd0);
        check("rstmid_ram_addr", 32'(ram_addr), 32'd0);
        check("rstmid_vid_ack",  32'(vid_ack),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("rstmid_no_vid_ack", 32'(vid_ack), 32'd0);
            check("rstmid_idle_en",    32'(ram_en),  32'd0);
        end
        vid_read(12'hA10, al);
        check("rstmid_resume_latency", 32'(al), 32'd3);
        repeat (3) @(negedge clk);

        // Final report
        check("cpu_queue_empty", 32'(cpu_exp_q.size()), 32'd0);
        check("vid_queue_empty", 32'(vid_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
